// File: rtl/tx_jesd204b_pkg.sv
// Shared constants, state encoding and sizing helper for the JESD204B transmit link controller.
package tx_jesd204b_pkg;

  // 8b/10b control characters used by the link layer.
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;

  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } link_state_e;

  // Width of a counter that must hold values 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tx_jesd204b_link_ctrl_sync_req_filter.sv
// SYNC~ synchroniser plus low-run classifier: long runs are resync requests,
// short runs that end while the link is up are error reports and are counted.
module sync_req_filter
  import tx_jesd204b_pkg::*;
#(
  parameter int SYNC_REQ_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync_n,
  input  logic       count_en,
  output logic       sync_s,
  output logic       resync,
  output logic       err_pulse,
  output logic [7:0] err_cnt
);

  localparam int RW = cnt_width(SYNC_REQ_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(SYNC_REQ_LEN);
  localparam logic [RW-1:0] RUN_REQ = RW'(SYNC_REQ_LEN - 1);

  logic          sync_meta;
  logic [RW-1:0] run_cnt;

  // Two-flop synchroniser for the asynchronous SYNC~ input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= sync_n;
      sync_s    <= sync_meta;
    end
  end

  // Length of the current low run of sync_s, saturating once it qualifies as a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (!sync_s) begin
      if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
    end else begin
      run_cnt <= '0;
    end
  end

  // The current cycle is the SYNC_REQ_LEN-th consecutive low one, or later.
  assign resync    = !sync_s && (run_cnt >= RUN_REQ);
  // A short run has just ended while the link is in ILAS or DATA.
  assign err_pulse = sync_s && count_en && (run_cnt != '0) && (run_cnt < RUN_MAX);

  // Saturating count of error reports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (err_pulse && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tx_jesd204b_link_ctrl.sv
// Multi-lane JESD204B transmit link controller: free-running LMFC, CGS -> ILAS -> DATA
// sequencing from SYNC~, per-lane ILAS octet generation and registered lane outputs.
module tx_jesd204b_link_ctrl
  import tx_jesd204b_pkg::*;
#(
  parameter int         LANES        = 2,
  parameter int         F            = 2,
  parameter int         K            = 16,
  parameter int         ILAS_MF      = 4,
  parameter logic [7:0] DID          = 8'h5A,
  parameter int         SYNC_REQ_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_sync_n,
  input  logic [LANES*8-1:0] i_data,
  output logic               o_ready,
  output logic [LANES*8-1:0] o_data,
  output logic [LANES-1:0]   o_k,
  output logic               o_lmfc,
  output logic [1:0]         o_state,
  output logic [7:0]         o_err_cnt
);

  localparam int FK = F * K;
  localparam int OW = cnt_width(F);
  localparam int FW = cnt_width(K);
  localparam int PW = cnt_width(FK);
  localparam int MW = cnt_width(ILAS_MF + 1);

  localparam logic [OW-1:0] OCT_LAST  = OW'(F - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(K - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(FK - 1);
  localparam logic [PW-1:0] POS_K28_4 = PW'(1);
  localparam logic [PW-1:0] POS_DID   = PW'(2);
  localparam logic [PW-1:0] POS_LANE  = PW'(3);
  localparam logic [MW-1:0] MF_CFG    = MW'(1);
  localparam logic [MW-1:0] MF_DONE   = MW'(ILAS_MF);

  if (LANES < 1 || LANES > 8 || F < 1 || F > 256 || K < 1 || K > 32 ||
      FK < 5 || ILAS_MF < 2 || SYNC_REQ_LEN < 2) begin : g_param_check
    $error("tx_jesd204b_link_ctrl: unsupported parameter combination");
  end

  link_state_e        state, nxt;
  logic [OW-1:0]      oct_cnt;
  logic [FW-1:0]      frm_cnt;
  logic [PW-1:0]      pos_cnt;
  logic [MW-1:0]      mf_cnt, mf_nxt, m_eff;
  logic               boundary;
  logic               sync_s, resync, count_en, err_pulse_unused;
  logic [7:0]         ctrl_octet, ramp;
  logic               ctrl_k, lane_idx_sel;
  logic [LANES*8-1:0] lane_data;

  // The error pulse is kept available for a future status interrupt; only the count leaves this block.
  assign count_en = (state != ST_CGS);

  sync_req_filter #(
    .SYNC_REQ_LEN(SYNC_REQ_LEN)
  ) u_sync_req_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_n   (i_sync_n),
    .count_en (count_en),
    .sync_s   (sync_s),
    .resync   (resync),
    .err_pulse(err_pulse_unused),
    .err_cnt  (o_err_cnt)
  );

  // Free-running octet, frame and multiframe-position counters; they ignore the link state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oct_cnt <= '0;
      frm_cnt <= '0;
      pos_cnt <= '0;
    end else begin
      if (oct_cnt == OCT_LAST) begin
        oct_cnt <= '0;
        frm_cnt <= (frm_cnt == FRM_LAST) ? '0 : frm_cnt + 1'b1;
      end else begin
        oct_cnt <= oct_cnt + 1'b1;
      end
      pos_cnt <= (pos_cnt == POS_LAST) ? '0 : pos_cnt + 1'b1;
    end
  end

  assign boundary = (oct_cnt == '0) && (frm_cnt == '0);
  assign ramp     = 8'(pos_cnt);

  // Next link state; a resync request overrides any LMFC-driven transition.
  always_comb begin
    nxt = state;
    case (state)
      ST_CGS:  if (boundary && sync_s) nxt = ST_ILAS;
      ST_ILAS: if (boundary && (mf_cnt == MF_DONE)) nxt = ST_DATA;
      ST_DATA: nxt = ST_DATA;
      default: nxt = ST_CGS;
    endcase
    if (resync && (state != ST_CGS)) nxt = ST_CGS;
  end

  // ILAS multiframe index of the octet being emitted, and its value for the next octet.
  always_comb begin
    m_eff  = (state == ST_ILAS) ? mf_cnt : '0;
    mf_nxt = '0;
    if (nxt == ST_ILAS) mf_nxt = (pos_cnt == POS_LAST) ? m_eff + 1'b1 : m_eff;
  end

  // Lane-common control octet for CGS and ILAS; the lane-index slot is resolved per lane.
  always_comb begin
    ctrl_octet   = K28_5;
    ctrl_k       = 1'b1;
    lane_idx_sel = 1'b0;
    case (nxt)
      ST_ILAS: begin
        ctrl_octet = ramp;
        ctrl_k     = 1'b0;
        if (pos_cnt == '0) begin
          ctrl_octet = K28_0;
          ctrl_k     = 1'b1;
        end else if (pos_cnt == POS_LAST) begin
          ctrl_octet = K28_3;
          ctrl_k     = 1'b1;
        end else if (m_eff == MF_CFG) begin
          if (pos_cnt == POS_K28_4) begin
            ctrl_octet = K28_4;
            ctrl_k     = 1'b1;
          end else if (pos_cnt == POS_DID) begin
            ctrl_octet = DID;
          end else if (pos_cnt == POS_LANE) begin
            lane_idx_sel = 1'b1;
          end
        end
      end
      ST_DATA: ctrl_k = 1'b0;
      default: ;
    endcase
  end

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    localparam logic [7:0] LANE_ID = 8'(n);
    assign lane_data[8*n +: 8] = (nxt == ST_DATA) ? i_data[8*n +: 8] :
                                 (lane_idx_sel ? LANE_ID : ctrl_octet);
  end

  // Output registers and link state; the octet emitted always belongs to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CGS;
      mf_cnt  <= '0;
      o_data  <= '0;
      o_k     <= '0;
      o_ready <= 1'b0;
      o_lmfc  <= 1'b0;
    end else begin
      state   <= nxt;
      mf_cnt  <= mf_nxt;
      o_data  <= lane_data;
      o_k     <= {LANES{ctrl_k}};
      o_ready <= (nxt == ST_DATA);
      o_lmfc  <= boundary;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_tx_jesd204b_link_ctrl.sv
// Directed self-checking bench for tx_jesd204b_link_ctrl with LANES=2, F=2, K=16 (32-octet multiframe).
module tb_tx_jesd204b_link_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_sync_n;
  logic [15:0] i_data;
  logic        o_ready;
  logic [15:0] o_data;
  logic [1:0]  o_k;
  logic        o_lmfc;
  logic [1:0]  o_state;
  logic [7:0]  o_err_cnt;

  int total;
  int bad;
  int edge_n;

  tx_jesd204b_link_ctrl #(
    .LANES(2), .F(2), .K(16), .ILAS_MF(4), .DID(8'h5A), .SYNC_REQ_LEN(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sync_n (i_sync_n),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_k      (o_k),
    .o_lmfc   (o_lmfc),
    .o_state  (o_state),
    .o_err_cnt(o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one character clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    i_sync_n = 1'b0;
    i_data   = 16'h0000;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++; if (o_data !== 16'h0000) begin bad++; $display("[TB] FAIL reset_data: got %h want 0000", o_data); end
    total++; if (o_k !== 2'b00) begin bad++; $display("[TB] FAIL reset_k: got %b want 00", o_k); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", o_ready); end
    total++; if (o_lmfc !== 1'b0) begin bad++; $display("[TB] FAIL reset_lmfc: got %b want 0", o_lmfc); end
    total++; if (o_state !== 2'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", o_state); end
    total++; if (o_err_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_err: got %0d want 0", o_err_cnt); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_cgs();
    for (int i = 0; i < 100; i++) begin
      tick();
      total++; if (o_data !== 16'hBCBC || o_k !== 2'b11) begin bad++; $display("[TB] FAIL cgs_octet edge %0d: got %h/%b want bcbc/11", edge_n, o_data, o_k); end
      total++; if (o_ready !== 1'b0 || o_state !== 2'd0) begin bad++; $display("[TB] FAIL cgs_state edge %0d: got ready=%b state=%0d want 0/0", edge_n, o_ready, o_state); end
      total++; if (o_err_cnt !== 8'd0) begin bad++; $display("[TB] FAIL cgs_err edge %0d: got %0d want 0", edge_n, o_err_cnt); end
      total++; if (o_lmfc !== ((edge_n - 1) % 32 == 0)) begin bad++; $display("[TB] FAIL cgs_lmfc edge %0d: got %b", edge_n, o_lmfc); end
    end
  endtask

  task automatic test_ilas();
    int m;
    int p;
    logic [15:0] ed;
    logic [1:0]  ek;
    // Released at octet 3 of the multiframe that started at edge 97; ILAS must wait for edge 129.
    i_sync_n = 1'b1;
    while (edge_n < 128) begin
      tick();
      total++; if (o_state !== 2'd0 || o_data !== 16'hBCBC) begin bad++; $display("[TB] FAIL ilas_wait edge %0d: got state=%0d data=%h want 0/bcbc", edge_n, o_state, o_data); end
    end
    for (int i = 0; i < 128; i++) begin
      tick();
      m = i / 32;
      p = i % 32;
      if (p == 0) begin
        ed = 16'h1C1C; ek = 2'b11;
      end else if (p == 31) begin
        ed = 16'h7C7C; ek = 2'b11;
      end else if (m == 1 && p == 1) begin
        ed = 16'h9C9C; ek = 2'b11;
      end else if (m == 1 && p == 2) begin
        ed = 16'h5A5A; ek = 2'b00;
      end else if (m == 1 && p == 3) begin
        ed = 16'h0100; ek = 2'b00;
      end else begin
        ed = {8'(p), 8'(p)}; ek = 2'b00;
      end
      total++; if (o_data !== ed) begin bad++; $display("[TB] FAIL ilas_data mf %0d pos %0d: got %h want %h", m, p, o_data, ed); end
      total++; if (o_k !== ek) begin bad++; $display("[TB] FAIL ilas_k mf %0d pos %0d: got %b want %b", m, p, o_k, ek); end
      total++; if (o_state !== 2'd1 || o_ready !== 1'b0) begin bad++; $display("[TB] FAIL ilas_state mf %0d pos %0d: got state=%0d ready=%b want 1/0", m, p, o_state, o_ready); end
      total++; if (o_lmfc !== (p == 0)) begin bad++; $display("[TB] FAIL ilas_lmfc mf %0d pos %0d: got %b", m, p, o_lmfc); end
    end
  endtask

  task automatic test_data();
    logic [15:0] v;
    for (int i = 0; i < 40; i++) begin
      v = {8'(2 * i + 1), 8'(2 * i)};
      i_data = v;
      tick();
      total++; if (o_data !== v) begin bad++; $display("[TB] FAIL data_pass beat %0d: got %h want %h", i, o_data, v); end
      total++; if (o_k !== 2'b00) begin bad++; $display("[TB] FAIL data_k beat %0d: got %b want 00", i, o_k); end
      total++; if (o_state !== 2'd2 || o_ready !== 1'b1) begin bad++; $display("[TB] FAIL data_state beat %0d: got state=%0d ready=%b want 2/1", i, o_state, o_ready); end
      total++; if (o_lmfc !== ((edge_n - 1) % 32 == 0)) begin bad++; $display("[TB] FAIL data_lmfc edge %0d: got %b", edge_n, o_lmfc); end
      i_data = ~v;
      #1;
      total++; if (o_data !== v) begin bad++; $display("[TB] FAIL data_hold beat %0d: got %h want %h", i, o_data, v); end
    end
    i_data = 16'hA55A;
  endtask

  task automatic test_err_reports();
    for (int n = 1; n <= 3; n++) begin
      i_sync_n = 1'b0;
      tick();
      tick();
      i_sync_n = 1'b1;
      for (int j = 0; j < 6; j++) tick();
      total++; if (o_err_cnt !== 8'(n)) begin bad++; $display("[TB] FAIL err_count pulse %0d: got %0d want %0d", n, o_err_cnt, n); end
      total++; if (o_state !== 2'd2 || o_ready !== 1'b1) begin bad++; $display("[TB] FAIL err_state pulse %0d: got state=%0d ready=%b want 2/1", n, o_state, o_ready); end
    end
    total++; if (o_data !== 16'hA55A) begin bad++; $display("[TB] FAIL err_data: got %h want a55a", o_data); end
    for (int n = 0; n < 300; n++) begin
      i_sync_n = 1'b0;
      tick();
      tick();
      i_sync_n = 1'b1;
      tick();
      tick();
      tick();
    end
    for (int j = 0; j < 4; j++) tick();
    total++; if (o_err_cnt !== 8'd255) begin bad++; $display("[TB] FAIL err_saturate: got %0d want 255", o_err_cnt); end
    total++; if (o_state !== 2'd2) begin bad++; $display("[TB] FAIL err_sat_state: got %0d want 2", o_state); end
  endtask

  task automatic test_resync();
    int e0;
    int b;
    // Line up so the state change lands exactly on an LMFC boundary.
    while ((edge_n + 5) % 32 != 0) tick();
    e0 = edge_n;
    i_sync_n = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      if (j == 5) i_sync_n = 1'b1;
      tick();
      total++; if (o_state !== 2'd2) begin bad++; $display("[TB] FAIL resync_early edge +%0d: got state %0d want 2", j, o_state); end
    end
    tick();
    total++; if (o_state !== 2'd0 || o_ready !== 1'b0) begin bad++; $display("[TB] FAIL resync_state: got state=%0d ready=%b want 0/0", o_state, o_ready); end
    total++; if (o_data !== 16'hBCBC || o_k !== 2'b11) begin bad++; $display("[TB] FAIL resync_octet: got %h/%b want bcbc/11", o_data, o_k); end
    total++; if (o_lmfc !== 1'b1) begin bad++; $display("[TB] FAIL resync_lmfc: got %b want 1", o_lmfc); end
    total++; if (o_err_cnt !== 8'd255) begin bad++; $display("[TB] FAIL resync_err: got %0d want 255", o_err_cnt); end
    b = e0 + 6 + 32;
    while (edge_n < b - 1) begin
      tick();
      total++; if (o_state !== 2'd0 || o_data !== 16'hBCBC) begin bad++; $display("[TB] FAIL resync_cgs edge %0d: got state=%0d data=%h", edge_n, o_state, o_data); end
      total++; if (o_lmfc !== 1'b0) begin bad++; $display("[TB] FAIL resync_lmfc_gap edge %0d: got %b want 0", edge_n, o_lmfc); end
    end
    tick();
    total++; if (o_state !== 2'd1 || o_data !== 16'h1C1C || o_k !== 2'b11) begin bad++; $display("[TB] FAIL resync_ilas: got state=%0d data=%h k=%b want 1/1c1c/11", o_state, o_data, o_k); end
    total++; if (o_lmfc !== 1'b1) begin bad++; $display("[TB] FAIL resync_ilas_lmfc: got %b want 1", o_lmfc); end
  endtask

  task automatic test_reset_mid_ilas();
    for (int j = 0; j < 5; j++) tick();
    total++; if (o_state !== 2'd1) begin bad++; $display("[TB] FAIL mid_pre_state: got %0d want 1", o_state); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (o_data !== 16'h0000 || o_k !== 2'b00) begin bad++; $display("[TB] FAIL mid_rst_octet: got %h/%b want 0000/00", o_data, o_k); end
    total++; if (o_state !== 2'd0 || o_ready !== 1'b0 || o_lmfc !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_ctrl: got state=%0d ready=%b lmfc=%b", o_state, o_ready, o_lmfc); end
    total++; if (o_err_cnt !== 8'd0) begin bad++; $display("[TB] FAIL mid_rst_err: got %0d want 0", o_err_cnt); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    edge_n = 0;
    for (int j = 0; j < 33; j++) begin
      tick();
      total++; if (o_lmfc !== (edge_n == 1 || edge_n == 33)) begin bad++; $display("[TB] FAIL mid_lmfc edge %0d: got %b", edge_n, o_lmfc); end
      if (edge_n < 33) begin
        total++; if (o_state !== 2'd0 || o_data !== 16'hBCBC) begin bad++; $display("[TB] FAIL mid_cgs edge %0d: got state=%0d data=%h", edge_n, o_state, o_data); end
      end else begin
        total++; if (o_state !== 2'd1 || o_data !== 16'h1C1C) begin bad++; $display("[TB] FAIL mid_ilas edge %0d: got state=%0d data=%h", edge_n, o_state, o_data); end
      end
    end
    total++; if (o_err_cnt !== 8'd0) begin bad++; $display("[TB] FAIL mid_err_after: got %0d want 0", o_err_cnt); end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    edge_n = 0;
    test_reset();
    test_cgs();
    test_ilas();
    test_data();
    test_err_reports();
    test_resync();
    test_reset_mid_ilas();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
